// File: rtl/compress_s1_ctrl.sv
// Stage-1 compression sequencer: presents each input word to the comparator
// array with the current dictionary, then emits one code record per word.
module compress_s1_ctrl #(
  parameter int WIDTH = 32,
  parameter int WORDS = 16,
  parameter int PTRW  = $clog2(WORDS)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic [WIDTH-1:0]       i_word,
  input  logic                   i_last,
  output logic                   o_ready,
  output logic [WIDTH-1:0]       o_cmp_word,
  output logic [WORDS*WIDTH-1:0] o_dictionary,
  input  logic                   i_cmp_match,
  input  logic                   i_cmp_type,
  input  logic [11:0]            i_cmp_code,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [11:0]            o_code,
  output logic                   o_raw,
  output logic [WIDTH-1:0]       o_word,
  output logic                   o_last,
  output logic [PTRW:0]          o_dict_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_OUT  = 2'd2,
    ST_CLR  = 2'd3
  } state_t;

  localparam logic [PTRW:0] COUNT_FULL = (PTRW+1)'(WORDS);

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] cmp_word_r;
  logic             last_r;
  logic [WIDTH-1:0] dict_r [WORDS];
  logic [PTRW-1:0]  wr_ptr_r;
  logic [PTRW:0]    count_r;
  logic             valid_r;
  logic [11:0]      code_r;
  logic             raw_r;
  logic [WIDTH-1:0] word_out_r;
  logic             last_out_r;
  logic             miss_s;

  assign miss_s = ~(i_cmp_match | i_cmp_type);

  // Next-state logic for the IDLE -> CMP -> OUT (-> CLR) sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_valid) begin
          state_s = ST_CMP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CMP: begin
        state_s = ST_OUT;
      end
      ST_OUT: begin
        if (i_ready) begin
          if (last_r) begin
            state_s = ST_CLR;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_OUT;
        end
      end
      ST_CLR: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Word capture, record capture and dictionary FIFO maintenance.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cmp_word_r <= '0;
      last_r     <= 1'b0;
      wr_ptr_r   <= '0;
      count_r    <= '0;
      valid_r    <= 1'b0;
      code_r     <= 12'h000;
      raw_r      <= 1'b0;
      word_out_r <= '0;
      last_out_r <= 1'b0;
      for (int k = 0; k < WORDS; k++) begin
        dict_r[k] <= '0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_valid) begin
            cmp_word_r <= i_word;
            last_r     <= i_last;
          end
        end
        ST_CMP: begin
          code_r     <= i_cmp_code;
          word_out_r <= cmp_word_r;
          raw_r      <= miss_s;
          last_out_r <= last_r;
          valid_r    <= 1'b1;
          // Only a miss enters the dictionary; the oldest entry is overwritten on wrap.
          if (miss_s) begin
            dict_r[wr_ptr_r] <= cmp_word_r;
            wr_ptr_r         <= wr_ptr_r + PTRW'(1);
            if (count_r != COUNT_FULL) begin
              count_r <= count_r + (PTRW+1)'(1);
            end
          end
        end
        ST_OUT: begin
          if (i_ready) begin
            valid_r <= 1'b0;
          end
        end
        ST_CLR: begin
          wr_ptr_r <= '0;
          count_r  <= '0;
          for (int k = 0; k < WORDS; k++) begin
            dict_r[k] <= '0;
          end
        end
        default: begin
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < WORDS; g++) begin : g_dict_flat
    assign o_dictionary[g*WIDTH +: WIDTH] = dict_r[g];
  end

  assign o_ready      = (state_r == ST_IDLE);
  assign o_cmp_word   = cmp_word_r;
  assign o_valid      = valid_r;
  assign o_code       = code_r;
  assign o_raw        = raw_r;
  assign o_word       = word_out_r;
  assign o_last       = last_out_r;
  assign o_dict_count = count_r;

endmodule

// File: tb/tb_compress_s1_ctrl.sv
// Self-checking bench for compress_s1_ctrl: directed vector table, hand-written
// wrap/reset sequences and random traffic against a dictionary reference model.
module tb_compress_s1_ctrl;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [31:0]   in_word;
  logic          in_last;
  logic          rdy;
  logic [31:0]   cmp_word;
  logic [511:0]  dict;
  logic          cmp_match;
  logic          cmp_type;
  logic [11:0]   cmp_code;
  logic          out_valid;
  logic          ds_ready;
  logic [11:0]   code;
  logic          raw;
  logic [31:0]   oword;
  logic          olast;
  logic [4:0]    dcount;

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_dict [16];
  int          ref_misses;

  compress_s1_ctrl dut (
    .i_clk(clk), .i_reset(rst), .i_valid(in_valid), .i_word(in_word), .i_last(in_last),
    .o_ready(rdy), .o_cmp_word(cmp_word), .o_dictionary(dict),
    .i_cmp_match(cmp_match), .i_cmp_type(cmp_type), .i_cmp_code(cmp_code),
    .o_valid(out_valid), .i_ready(ds_ready), .o_code(code), .o_raw(raw),
    .o_word(oword), .o_last(olast), .o_dict_count(dcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator-array stand-in: {match, type_matched, code}
  function automatic logic [13:0] cmp_fn(input logic [31:0] w, input logic [511:0] d);
    if (w == 32'h0) return {1'b1, 1'b0, 12'h000};
    if (w[31:8] == 24'h0) return {1'b1, 1'b0, 4'hD, w[7:0]};
    for (int k = 0; k < 16; k++) begin
      if (d[k*32 +: 32] == w) return {1'b0, 1'b1, 8'h80, 4'(k)};
    end
    return {1'b0, 1'b0, w[11:0] ^ 12'h5A5};
  endfunction

  always_comb {cmp_match, cmp_type, cmp_code} = cmp_fn(cmp_word, dict);

  function automatic logic [511:0] ref_flat();
    logic [511:0] f;
    for (int k = 0; k < 16; k++) f[k*32 +: 32] = ref_dict[k];
    return f;
  endfunction

  function automatic int ref_count();
    return (ref_misses > 16) ? 16 : ref_misses;
  endfunction

  task automatic ref_clear();
    for (int k = 0; k < 16; k++) ref_dict[k] = 32'h0;
    ref_misses = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_dict(input string nm);
    int first_bad;
    first_bad = -1;
    total++;
    for (int k = 0; k < 16; k++) begin
      if (dict[k*32 +: 32] !== ref_dict[k] && first_bad < 0) first_bad = k;
    end
    if (first_bad >= 0) begin
      bad++;
      $display("FAIL %s: entry %0d got %0h expected %0h", nm, first_bad,
               dict[first_bad*32 +: 32], ref_dict[first_bad]);
    end
  endtask

  // Sends one word and checks it end to end. Called and returns at a negedge.
  task automatic send_word(input logic [31:0] w, input logic l, input int stall,
                           output logic [11:0] rc, output logic rr);
    int n;
    logic [13:0] e;
    logic er;
    n = 0;
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'h0, rdy}, 32'h1);
    in_valid = 1'b1; in_word = w; in_last = l;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk("cmp_word", cmp_word, w);
    chk("cmp_phase_valid", {31'h0, out_valid}, 32'h0);
    chk("cmp_phase_ready", {31'h0, rdy}, 32'h0);
    chk_dict("dict_before_cmp");
    e  = cmp_fn(w, ref_flat());
    er = ~(e[13] | e[12]);
    if (er) begin
      ref_dict[ref_misses % 16] = w;
      ref_misses++;
    end
    @(posedge clk); @(negedge clk);
    chk("rec_valid", {31'h0, out_valid}, 32'h1);
    chk("rec_code", {20'h0, code}, {20'h0, e[11:0]});
    chk("rec_raw", {31'h0, raw}, {31'h0, er});
    chk("rec_word", oword, w);
    chk("rec_last", {31'h0, olast}, {31'h0, l});
    chk("dict_count", {27'h0, dcount}, 32'(ref_count()));
    chk_dict("dict_after_cmp");
    rc = code; rr = raw;
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1; in_word = ~w;
      @(negedge clk);
      chk("stall_valid", {31'h0, out_valid}, 32'h1);
      chk("stall_code", {20'h0, code}, {20'h0, e[11:0]});
      chk("stall_word", oword, w);
      chk("stall_ready", {31'h0, rdy}, 32'h0);
      chk("stall_cmp_word", cmp_word, w);
    end
    in_valid = 1'b0;
    ds_ready = 1'b1;
    @(negedge clk);
    ds_ready = 1'b0;
    chk("post_hs_valid", {31'h0, out_valid}, 32'h0);
    if (l) begin
      chk("clr_ready", {31'h0, rdy}, 32'h0);
      @(negedge clk);
      ref_clear();
      chk_dict("dict_cleared");
      chk("count_cleared", {27'h0, dcount}, 32'h0);
    end
    chk("back_idle_ready", {31'h0, rdy}, 32'h1);
  endtask

  typedef struct {
    logic [31:0] word;
    logic        last;
    int          stall;
    logic        exp_raw;
    logic [11:0] exp_code;
  } vec_t;

  vec_t        vecs [5];
  logic [11:0] rc;
  logic        rr;
  logic [31:0] w;
  logic        l;

  initial begin
    vecs[0] = '{32'h00000000, 1'b0, 0, 1'b0, 12'h000};
    vecs[1] = '{32'h0000005A, 1'b0, 0, 1'b0, 12'hD5A};
    vecs[2] = '{32'h11111101, 1'b0, 0, 1'b1, 12'h4A4};
    vecs[3] = '{32'h11111101, 1'b0, 5, 1'b0, 12'h800};
    vecs[4] = '{32'h22222222, 1'b1, 0, 1'b1, 12'h787};

    rst = 1'b1; in_valid = 1'b0; in_word = 32'h0; in_last = 1'b0; ds_ready = 1'b0;
    ref_clear();
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, rdy}, 32'h1);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_count", {27'h0, dcount}, 32'h0);
    chk("rst_cmp_word", cmp_word, 32'h0);
    chk("rst_code", {20'h0, code}, 32'h0);
    chk("rst_raw", {31'h0, raw}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      send_word(vecs[i].word, vecs[i].last, vecs[i].stall, rc, rr);
      chk("tab_code", {20'h0, rc}, {20'h0, vecs[i].exp_code});
      chk("tab_raw", {31'h0, rr}, {31'h0, vecs[i].exp_raw});
    end

    // Seventeen misses wrap the dictionary; the 17th closes the line.
    for (int k = 1; k <= 16; k++) begin
      send_word(32'h11111100 + 32'(k), 1'b0, 0, rc, rr);
    end
    chk("wrap_count_full", {27'h0, dcount}, 32'd16);
    for (int k = 1; k <= 16; k++) begin
      chk("wrap_entry", dict[(k-1)*32 +: 32], 32'h11111100 + 32'(k));
    end
    send_word(32'h11111111, 1'b1, 0, rc, rr);
    chk("wrap_last_raw", {31'h0, rr}, 32'h1);

    // Random traffic; the final word closes its line.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0:       w = 32'h0;
        1:       w = 32'($urandom_range(1, 255));
        default: w = 32'h30000000 | 32'($urandom_range(0, 30));
      endcase
      l = ($urandom_range(0, 7) == 0) || (i == 149);
      send_word(w, l, $urandom_range(0, 2), rc, rr);
    end

    // Reset while a record is pending with three dictionary entries.
    send_word(32'h44440001, 1'b0, 0, rc, rr);
    send_word(32'h44440002, 1'b0, 0, rc, rr);
    in_valid = 1'b1; in_word = 32'h44440003; in_last = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("pre_rst_valid", {31'h0, out_valid}, 32'h1);
    chk("pre_rst_count", {27'h0, dcount}, 32'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_ready", {31'h0, rdy}, 32'h1);
    chk("mid_rst_code", {20'h0, code}, 32'h0);
    chk("mid_rst_word", oword, 32'h0);
    chk("mid_rst_cmp_word", cmp_word, 32'h0);
    chk("mid_rst_count", {27'h0, dcount}, 32'h0);
    ref_clear();
    chk_dict("mid_rst_dict");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_word(32'h55550001, 1'b0, 0, rc, rr);
    chk("post_rst_raw", {31'h0, rr}, 32'h1);
    chk("post_rst_entry0", dict[31:0], 32'h55550001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
